// File: rtl/hex_display_ctrl.sv
// Upstream stage for the six seven-segment decoders. It captures a 32-bit word on load,
// pages the eight nibbles onto six digits with a debounced button, and applies suppression and blink.
module hex_display_ctrl #(
    parameter int DEB_CYCLES = 50000,
    parameter int BLINK_HALF = 12500000,
    parameter bit LZS        = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] value,
    input  logic        load,
    input  logic        npage_btn,
    input  logic        blink,
    output logic [23:0] din,
    output logic [5:0]  en,
    output logic [5:0]  dot,
    output logic        page
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [5:0] EN_RST = LZS ? 6'b000001 : 6'b111111;

    logic [31:0]   val;
    logic          sync1;
    logic          sync2;
    logic          stb;
    logic [DW-1:0] deb_cnt;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    logic [23:0]   map_din;
    logic [5:0]    map_en;
    logic [5:0]    map_dot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val <= '0;
        end else if (load) begin
            val <= value;
        end
    end

    // The button is asynchronous to clk; both stages idle high (released).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= npage_btn;
            sync2 <= sync1;
        end
    end

    // A level is accepted only after DEB_CYCLES consecutive differing samples.
    // Only the accepted 1->0 edge (a press) flips the page.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb     <= 1'b1;
            deb_cnt <= '0;
            page    <= 1'b0;
        end else if (sync2 == stb) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            stb     <= sync2;
            deb_cnt <= '0;
            if (stb && !sync2) begin
                page <= ~page;
            end
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (!blink) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Digit 0 always shows. Higher digits drop out when every nibble from them upward is zero.
    always_comb begin
        map_din = '0;
        map_en  = '0;
        map_dot = '0;
        if (!page) begin
            map_din   = val[23:0];
            map_en[0] = 1'b1;
            for (int k = 1; k < 6; k++) begin
                map_en[k] = !LZS || ((val >> (4 * k)) != 32'd0);
            end
        end else begin
            map_din[7:0] = val[31:24];
            map_en[0]    = 1'b1;
            map_en[1]    = !LZS || (val[31:28] != 4'd0);
            map_dot      = 6'b100000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din <= '0;
            en  <= EN_RST;
            dot <= '0;
        end else begin
            din <= map_din;
            en  <= map_en & {6{phase}};
            dot <= map_dot;
        end
    end

endmodule
